stream_rr_arbiter: RTL
======================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, payload width per requester and output.
REQ-002 Parameter: NUM_REQ, default 4, number of requesters; legal range 2..16.
REQ-003 Derived localparam: ID_WIDTH = clog2(NUM_REQ), width of requester index.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  NUM_REQ  per-requester valid.
REQ-007 in_ready  output  NUM_REQ  per-requester ready.
REQ-008 in_data  input  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 out_valid  output  1  registered output valid.
REQ-010 out_ready  input  1  downstream ready.
REQ-011 out_data  output  DATA_WIDTH  registered payload.
REQ-012 out_id  output  ID_WIDTH  index of the requester that sourced out_data, registered alongside it.

Function
REQ-013 Output stage SHALL be one register slice: can_load = !out_valid | out_ready.
REQ-014 Eligible set SHALL be all i with in_valid[i]=1 (restricted per REQ-026 when locked).
REQ-015 Grant g SHALL be the first eligible index at or after rr_ptr, wrapping NUM_REQ-1 -> 0; combinational, no bubble.
REQ-016 in_ready[i] SHALL be 1 only for i==g with an eligible set non-empty and can_load=1; all other bits 0.
REQ-017 in_ready SHALL never depend on in_valid of the same index through a register-free path beyond the grant selection.
REQ-018 On transfer (in_valid[g] & in_ready[g]): out_data <= in_data[g], out_id <= g, out_valid <= 1; latency input to output exactly 1 cycle.
REQ-019 With no transfer and out_ready=1: out_valid <= 0; with out_valid=1, out_ready=0: out_valid, out_data, out_id hold.
REQ-020 Simultaneous drain and load (out_valid=1, out_ready=1, transfer) SHALL sustain 1 beat/cycle.
REQ-021 rr_ptr SHALL update to (g+1) mod NUM_REQ on each arbitration release (every transfer; per packet when REQ-026 active); otherwise hold.
REQ-022 Fairness: any continuously valid requester SHALL be granted within NUM_REQ releases.

Reset
REQ-023 While rst_n=0: out_valid=0, out_data=0, out_id=0, rr_ptr=0, lock state IDLE; in_ready all 0 only as a consequence of empty eligibility or can_load.
REQ-024 Reset assertion mid-transfer SHALL drop the in-flight beat; first cycle after deassertion arbitration starts at index 0.

Configuration
REQ-025 Macro STREAM_ARB_PKT_LOCK_EN SHALL add ports in_last (input, NUM_REQ) and out_last (output, 1, registered with out_data, reset 0).
REQ-026 With macro: FSM IDLE/LOCKED; IDLE->LOCKED on transfer with in_last[g]=0, storing lock_id=g; LOCKED eligible set = {lock_id} only; LOCKED->IDLE on transfer with in_last[lock_id]=1; rr_ptr updates only on IDLE/LOCKED->IDLE release; single-beat packet stays IDLE.
REQ-027 Without macro: no last ports, no FSM, every transfer is a release.

Structure
REQ-028 Package stream_arb_pkg SHALL hold lock-state enum typedef (ARB_IDLE, ARB_LOCKED) and default-parameter constants.
REQ-029 Sub-module rr_pick SHALL implement combinational round-robin selection (req vector, ptr -> grant index, grant_valid).

Verification
REQ-030 Reset: rst_n=0 then 1, all in_valid=0 -> out_valid=0, out_id=0, out_data=0.
REQ-031 All 4 requesters valid, data 0xA0..0xA3, out_ready=1 -> out_id sequence 0,1,2,3,0 one beat per cycle, data matches.
REQ-032 Only req 2 valid, rr_ptr=3 -> wrap grant to 2, out_id=2 next cycle, rr_ptr becomes 3.
REQ-033 out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_id stable, in_ready all 0; on out_ready=1 resume without loss or duplication.
REQ-034 Macro on: req 1 sends 3-beat packet (last on beat 3) while req 0 valid -> out_id 1,1,1 then 0; no interleave.
REQ-035 rst_n asserted while out_valid=1, out_ready=0 -> out_valid=0 immediately; after release first grant goes to lowest valid index.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
// Shared definitions for the stream round-robin arbiter:
//   - arb_state_e : packet-lock state (used when STREAM_ARB_PKT_LOCK_EN is set)
//   - DEF_*       : default parameter values for the arbiter top
//   - rr_next     : round-robin pointer successor with wrap at n-1 -> 0
// -----------------------------------------------------------------------------
package stream_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 4;

  // Successor of index g in a ring of n entries.
  function automatic int rr_next(input int g, input int n);
    return ((g + 1) >= n) ? 0 : (g + 1);
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first set bit of req at or
// after ptr, wrapping NUM_REQ-1 -> 0.
// Ports:
//   req         : request vector (one bit per requester)
//   ptr         : starting index for the search
//   grant       : selected index (0 when grant_valid is 0)
//   grant_valid : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] grant,
  output logic                grant_valid
);

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    int  idx_s;
    logic hit_s;
    grant       = '0;
    grant_valid = 1'b0;
    idx_s       = 0;
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s       = int'(ptr) + k;
      idx_s       = (idx_s >= NUM_REQ) ? (idx_s - NUM_REQ) : idx_s;
      hit_s       = !grant_valid && req[idx_s];
      grant       = hit_s ? ID_WIDTH'(idx_s) : grant;
      grant_valid = grant_valid | hit_s;
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
// NUM_REQ-to-1 valid/ready stream arbiter with round-robin fairness and a
// single registered output slice (full throughput, 1-cycle latency).
// Optional packet locking via macro STREAM_ARB_PKT_LOCK_EN: once a requester
// wins with in_last=0, it keeps the output until its beat with in_last=1.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : per-requester handshake
//   in_data                : requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_last  (macro only)  : per-requester end-of-packet
//   out_valid/out_ready    : output handshake (out_valid registered)
//   out_data/out_id        : registered payload and source index
//   out_last (macro only)  : registered end-of-packet
// -----------------------------------------------------------------------------
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            in_valid,
`ifdef STREAM_ARB_PKT_LOCK_EN
  input  logic [NUM_REQ-1:0]            in_last,
`endif
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
`ifdef STREAM_ARB_PKT_LOCK_EN
  output logic                          out_last,
`endif
  output logic [ID_WIDTH-1:0]           out_id
);

  logic [ID_WIDTH-1:0]   rr_ptr_r;
  logic [NUM_REQ-1:0]    eligible_s;
  logic [ID_WIDTH-1:0]   grant_s;
  logic                  grant_valid_s;
  logic                  can_load_s;
  logic                  xfer_s;
  logic                  release_s;
  logic [NUM_REQ-1:0]    in_ready_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [ID_WIDTH-1:0]   out_id_r;

  assign can_load_s = !out_valid_r || out_ready;
  // The grant is always an eligible (valid) index, so a transfer is simply
  // "someone is granted and the slice can accept".
  assign xfer_s     = grant_valid_s && can_load_s;
  assign sel_data_s = in_data[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH];

`ifdef STREAM_ARB_PKT_LOCK_EN
  arb_state_e          state_r, state_n_s;
  logic [ID_WIDTH-1:0] lock_id_r, lock_id_n_s;
  logic                out_last_r;

  // While locked only the owning requester may compete.
  assign eligible_s = (state_r == ARB_LOCKED)
                    ? (in_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << lock_id_r))
                    : in_valid;

  // Lock FSM next state; the pointer is released only at packet end.
  always_comb begin
    state_n_s   = state_r;
    lock_id_n_s = lock_id_r;
    release_s   = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (xfer_s && !in_last[grant_s]) begin
          state_n_s   = ARB_LOCKED;
          lock_id_n_s = grant_s;
        end else begin
          release_s   = xfer_s;
        end
      end
      ARB_LOCKED: begin
        if (xfer_s && in_last[lock_id_r]) begin
          state_n_s = ARB_IDLE;
          release_s = 1'b1;
        end else begin
          release_s = 1'b0;
        end
      end
      default: begin
        state_n_s = ARB_IDLE;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ARB_IDLE;
      lock_id_r <= '0;
    end else begin
      state_r   <= state_n_s;
      lock_id_r <= lock_id_n_s;
    end
  end

  // End-of-packet flag travels with the payload register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_last_r <= 1'b0;
    end else if (xfer_s) begin
      out_last_r <= in_last[grant_s];
    end
  end

  assign out_last = out_last_r;
`else
  assign eligible_s = in_valid;
  assign release_s  = xfer_s;
`endif

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req         (eligible_s),
    .ptr         (rr_ptr_r),
    .grant       (grant_s),
    .grant_valid (grant_valid_s)
  );

  // One-hot ready toward the granted requester only when the slice can load.
  always_comb begin
    in_ready_s = '0;
    if (xfer_s) begin
      in_ready_s[grant_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  assign in_ready = in_ready_s;

  // Round-robin pointer advances past the winner on each release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (release_s) begin
      rr_ptr_r <= ID_WIDTH'(rr_next(int'(grant_s), NUM_REQ));
    end
  end

  // Output register slice: load on transfer, drop when drained, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= '0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_data_s;
      out_id_r    <= grant_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;

endmodule
